// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - writeback, multicycle-result and register-file write port bundle for rf_write_arbiter
interface rf_write_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_wr;
    logic [31:0] wb_wd;
    logic        wb_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_wr;
    logic [31:0] mdu_wd;
    logic        mdu_ready;
    logic        rf_Write;
    logic [4:0]  rf_WR;
    logic [31:0] rf_WD;
    logic [4:0]  PR1;
    logic [4:0]  PR2;
    logic        hz1;
    logic        hz2;

    modport master (
        output wb_we, wb_wr, wb_wd, mdu_valid, mdu_wr, mdu_wd, PR1, PR2,
        input  wb_stall, mdu_ready, rf_Write, rf_WR, rf_WD, hz1, hz2
    );

    modport slave (
        input  wb_we, wb_wr, wb_wd, mdu_valid, mdu_wr, mdu_wd, PR1, PR2,
        output wb_stall, mdu_ready, rf_Write, rf_WR, rf_WD, hz1, hz2
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - single-port register-file write arbiter: writeback vs 2-entry multicycle result FIFO
// Optional head starvation guard enabled by macro RFARB_STARVE_GUARD_EN.
module rf_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic           Clk,
    input logic           Reset,
    rf_write_arbiter_if.slave bus
);

    logic [4:0]  fifo_wr [2];
    logic [31:0] fifo_wd [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;

    logic wb_valid;
    logic fifo_empty;
    logic force_head;
    logic grant_wb;
    logic grant_head;
    logic push;
    logic occ0;
    logic occ1;

    // Outputs are gated by Reset so the write port stays quiet for the whole reset window.
    always_comb begin
        wb_valid      = !Reset && bus.wb_we && (bus.wb_wr != 5'd0);
        fifo_empty    = (count == 2'd0);
        grant_wb      = wb_valid && !force_head;
        grant_head    = !Reset && !grant_wb && !fifo_empty;
        bus.mdu_ready = (count < 2'd2);
        push          = !Reset && bus.mdu_valid && bus.mdu_ready && (bus.mdu_wr != 5'd0);
        bus.wb_stall  = wb_valid && grant_head;

        bus.rf_Write = grant_wb || grant_head;
        bus.rf_WR    = 5'd0;
        bus.rf_WD    = 32'd0;
        if (grant_wb) begin
            bus.rf_WR = bus.wb_wr;
            bus.rf_WD = bus.wb_wd;
        end else if (grant_head) begin
            bus.rf_WR = fifo_wr[head];
            bus.rf_WD = fifo_wd[head];
        end

        occ0    = (count == 2'd2) || ((count == 2'd1) && (head == 1'b0));
        occ1    = (count == 2'd2) || ((count == 2'd1) && (head == 1'b1));
        bus.hz1 = !Reset && (bus.PR1 != 5'd0) &&
                  ((occ0 && (fifo_wr[0] == bus.PR1)) ||
                   (occ1 && (fifo_wr[1] == bus.PR1)) ||
                   (push && (bus.mdu_wr == bus.PR1)));
        bus.hz2 = !Reset && (bus.PR2 != 5'd0) &&
                  ((occ0 && (fifo_wr[0] == bus.PR2)) ||
                   (occ1 && (fifo_wr[1] == bus.PR2)) ||
                   (push && (bus.mdu_wr == bus.PR2)));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count      <= 2'd0;
            head       <= 1'b0;
            tail       <= 1'b0;
            fifo_wr[0] <= 5'd0;
            fifo_wr[1] <= 5'd0;
            fifo_wd[0] <= 32'd0;
            fifo_wd[1] <= 32'd0;
        end else begin
            if (push) begin
                fifo_wr[tail] <= bus.mdu_wr;
                fifo_wd[tail] <= bus.mdu_wd;
                tail          <= ~tail;
            end
            if (grant_head) begin
                head <= ~head;
            end
            count <= count + {1'b0, push} - {1'b0, grant_head};
        end
    end

`ifdef RFARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    // Saturates so a long WB burst cannot wrap the counter back below the limit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            starve_cnt <= 4'd0;
        end else if (fifo_empty || grant_head) begin
            starve_cnt <= 4'd0;
        end else if (grant_wb && (starve_cnt != 4'hF)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign force_head = (starve_cnt >= 4'(STARVE_LIMIT));
`else
    assign force_head = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard bench for rf_write_arbiter
module tb_rf_write_arbiter;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    rf_write_arbiter_if bus();

    rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [36:0] exp_q[$];
    logic [36:0] mon_exp;
    logic        exp_stall;
    int          k;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (bus.rf_Write === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", 64'(bus.rf_Write), 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("write_order", 64'({bus.rf_WR, bus.rf_WD}), 64'(mon_exp));
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic sample();
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        bus.wb_we     = 1'b0;
        bus.wb_wr     = 5'd0;
        bus.wb_wd     = 32'd0;
        bus.mdu_valid = 1'b0;
        bus.mdu_wr    = 5'd0;
        bus.mdu_wd    = 32'd0;
        bus.PR1       = 5'd0;
        bus.PR2       = 5'd0;
    endtask

    task automatic wb(input logic [4:0] wr, input logic [31:0] wd);
        bus.wb_we = 1'b1;
        bus.wb_wr = wr;
        bus.wb_wd = wd;
    endtask

    task automatic offer(input logic [4:0] wr, input logic [31:0] wd);
        bus.mdu_valid = 1'b1;
        bus.mdu_wr    = wr;
        bus.mdu_wd    = wd;
    endtask

    task automatic expect_write(input logic [4:0] wr, input logic [31:0] wd);
        exp_q.push_back({wr, wd});
    endtask

    initial begin
        idle_inputs();
        Reset = 1'b1;
        wb(5'd3, 32'h1);
        offer(5'd5, 32'h5);
        bus.PR1 = 5'd5;
        sample();
        check("rst_rf_write", 64'(bus.rf_Write), 64'd0);
        check("rst_rf_wr", 64'(bus.rf_WR), 64'd0);
        check("rst_rf_wd", 64'(bus.rf_WD), 64'd0);
        check("rst_wb_stall", 64'(bus.wb_stall), 64'd0);
        check("rst_mdu_ready", 64'(bus.mdu_ready), 64'd1);
        check("rst_hz1", 64'(bus.hz1), 64'd0);
        check("rst_hz2", 64'(bus.hz2), 64'd0);
        step();
        idle_inputs();
        Reset = 1'b0;
        sample();
        check("post_rst_rf_write", 64'(bus.rf_Write), 64'd0);
        check("post_rst_mdu_ready", 64'(bus.mdu_ready), 64'd1);

        // single offer, one-cycle latency
        step();
        offer(5'd5, 32'hA5A5A5A5);
        bus.PR1 = 5'd5;
        expect_write(5'd5, 32'hA5A5A5A5);
        sample();
        check("s1_no_bypass", 64'(bus.rf_Write), 64'd0);
        check("s1_ready_accept", 64'(bus.mdu_ready), 64'd1);
        check("s1_hz1_offer", 64'(bus.hz1), 64'd1);
        step();
        idle_inputs();
        sample();
        check("s1_write", 64'(bus.rf_Write), 64'd1);
        check("s1_wr", 64'(bus.rf_WR), 64'd5);
        check("s1_wd", 64'(bus.rf_WD), 64'hA5A5A5A5);
        check("s1_ready", 64'(bus.mdu_ready), 64'd1);
        step();
        sample();
        check("s1_idle", 64'(bus.rf_Write), 64'd0);

        // WB beats a waiting head
        step();
        offer(5'd7, 32'h77);
        expect_write(5'd3, 32'h1);
        expect_write(5'd7, 32'h77);
        sample();
        check("s2_empty", 64'(bus.rf_Write), 64'd0);
        step();
        idle_inputs();
        wb(5'd3, 32'h1);
        sample();
        check("s2_wb_wr", 64'(bus.rf_WR), 64'd3);
        check("s2_wb_stall", 64'(bus.wb_stall), 64'd0);
        step();
        idle_inputs();
        sample();
        check("s2_head_wr", 64'(bus.rf_WR), 64'd7);
        check("s2_head_stall", 64'(bus.wb_stall), 64'd0);
        step();
        sample();
        check("s2_idle", 64'(bus.rf_Write), 64'd0);

        // three offers against a busy WB
        step();
        wb(5'd10, 32'h100);
        offer(5'd20, 32'hD1);
        expect_write(5'd10, 32'h100);
        sample();
        check("s3_ready0", 64'(bus.mdu_ready), 64'd1);
        step();
        wb(5'd10, 32'h101);
        offer(5'd21, 32'hD2);
        expect_write(5'd10, 32'h101);
        sample();
        check("s3_ready1", 64'(bus.mdu_ready), 64'd1);
        step();
        wb(5'd10, 32'h102);
        offer(5'd22, 32'hD3);
        expect_write(5'd10, 32'h102);
        sample();
        check("s3_full", 64'(bus.mdu_ready), 64'd0);
        step();
        wb(5'd10, 32'h103);
        expect_write(5'd10, 32'h103);
        sample();
        check("s3_full_held", 64'(bus.mdu_ready), 64'd0);
        expect_write(5'd20, 32'hD1);
        expect_write(5'd21, 32'hD2);
        expect_write(5'd22, 32'hD3);
        step();
        bus.wb_we = 1'b0;
        sample();
        check("s3_pop_no_push", 64'(bus.mdu_ready), 64'd0);
        check("s3_head20", 64'(bus.rf_WR), 64'd20);
        step();
        sample();
        check("s3_push_pop_ready", 64'(bus.mdu_ready), 64'd1);
        check("s3_head21", 64'(bus.rf_WR), 64'd21);
        step();
        bus.mdu_valid = 1'b0;
        sample();
        check("s3_head22", 64'(bus.rf_WR), 64'd22);
        step();
        sample();
        check("s3_idle", 64'(bus.rf_Write), 64'd0);

        // continuously busy WB with one waiting head
        step();
        offer(5'd9, 32'h99);
        sample();
        check("s4_empty", 64'(bus.rf_Write), 64'd0);
        step();
        idle_inputs();
        k = 0;
        for (int c = 1; c <= 6; c++) begin
            wb(5'd4, 32'h400 + 32'(k));
`ifdef RFARB_STARVE_GUARD_EN
            exp_stall = (c == 5);
`else
            exp_stall = 1'b0;
`endif
            if (exp_stall) begin
                expect_write(5'd9, 32'h99);
            end else begin
                expect_write(5'd4, 32'h400 + 32'(k));
                k++;
            end
            sample();
            check("s4_stall", 64'(bus.wb_stall), 64'(exp_stall));
            step();
        end
        bus.wb_we = 1'b0;
`ifdef RFARB_STARVE_GUARD_EN
        sample();
        check("s4_drained", 64'(bus.rf_Write), 64'd0);
`else
        expect_write(5'd9, 32'h99);
        sample();
        check("s4_late_head", 64'(bus.rf_WR), 64'd9);
`endif
        step();
        idle_inputs();

        // hazards and discarded x0 offer
        wb(5'd2, 32'h22);
        offer(5'd12, 32'hC);
        expect_write(5'd2, 32'h22);
        sample();
        check("s5_wb", 64'(bus.rf_WR), 64'd2);
        step();
        wb(5'd2, 32'h23);
        offer(5'd0, 32'hDEAD);
        bus.PR1 = 5'd12;
        bus.PR2 = 5'd0;
        expect_write(5'd2, 32'h23);
        sample();
        check("s5_hz1", 64'(bus.hz1), 64'd1);
        check("s5_hz2_zero", 64'(bus.hz2), 64'd0);
        check("s5_ready", 64'(bus.mdu_ready), 64'd1);
        step();
        wb(5'd2, 32'h24);
        bus.mdu_valid = 1'b0;
        bus.PR1 = 5'd13;
        bus.PR2 = 5'd12;
        expect_write(5'd2, 32'h24);
        sample();
        check("s5_hz1_miss", 64'(bus.hz1), 64'd0);
        check("s5_hz2", 64'(bus.hz2), 64'd1);
        check("s5_count_unchanged", 64'(bus.mdu_ready), 64'd1);
        step();
        bus.wb_we = 1'b0;
        bus.PR1 = 5'd12;
        bus.PR2 = 5'd0;
        expect_write(5'd12, 32'hC);
        sample();
        check("s5_head12", 64'(bus.rf_WR), 64'd12);
        check("s5_hz1_until_pop", 64'(bus.hz1), 64'd1);
        step();
        wb(5'd0, 32'h55);
        sample();
        check("s5_wb_x0_write", 64'(bus.rf_Write), 64'd0);
        check("s5_wb_x0_stall", 64'(bus.wb_stall), 64'd0);
        check("s5_hz1_cleared", 64'(bus.hz1), 64'd0);
        step();
        idle_inputs();

        // reset with two entries queued
        wb(5'd1, 32'h11);
        offer(5'd17, 32'h17);
        expect_write(5'd1, 32'h11);
        sample();
        step();
        wb(5'd1, 32'h12);
        offer(5'd18, 32'h18);
        expect_write(5'd1, 32'h12);
        sample();
        check("s6_ready_one", 64'(bus.mdu_ready), 64'd1);
        step();
        wb(5'd1, 32'h13);
        bus.mdu_valid = 1'b0;
        expect_write(5'd1, 32'h13);
        sample();
        check("s6_full", 64'(bus.mdu_ready), 64'd0);
        step();
        idle_inputs();
        bus.PR1 = 5'd17;
        #2;
        Reset = 1'b1;
        #1;
        check("s6_rst_write", 64'(bus.rf_Write), 64'd0);
        check("s6_rst_ready", 64'(bus.mdu_ready), 64'd1);
        check("s6_rst_hz1", 64'(bus.hz1), 64'd0);
        sample();
        check("s6_rst_hold", 64'(bus.rf_Write), 64'd0);
        step();
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sample();
            check("s6_no_stale", 64'(bus.rf_Write), 64'd0);
            step();
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive cycles the buffer head may be denied before it is forced (legal range 1..15).
REQ-002 SHALL have port Clk, input, 1 bit, the single clock; all state updates on the posedge.
REQ-003 SHALL have port Reset, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port wb_we, input, 1 bit, writeback-stage write request.
REQ-005 SHALL have ports wb_wr and wb_wd, inputs, 5 and 32 bits, writeback-stage destination register and data.
REQ-006 SHALL have port wb_stall, output, 1 bit; when high, the writeback request was not granted and the pipeline holds it.
REQ-007 SHALL have ports mdu_valid, mdu_wr and mdu_wd, inputs, 1, 5 and 32 bits, multicycle-unit result offer.
REQ-008 SHALL have port mdu_ready, output, 1 bit; the offer is accepted on an edge where mdu_valid and mdu_ready are both high.
REQ-009 SHALL have ports rf_Write, rf_WR and rf_WD, outputs, 1, 5 and 32 bits, driving the register-file write port.
REQ-010 SHALL have ports PR1 and PR2, inputs, 5 bits each, register-file read addresses being issued.
REQ-011 SHALL have ports hz1 and hz2, outputs, 1 bit each, pending-write hazard flags for PR1 and PR2.

Function
REQ-012 SHALL hold multicycle results in a 2-entry FIFO; mdu_ready = (count < 2), so there is no push while full even if a pop occurs in the same cycle.
REQ-013 SHALL accept an offer with mdu_wr == 0 and discard it without writing; such an offer does not occupy an entry.
REQ-014 SHALL ignore a writeback request with wb_wr == 0: no write and no stall.
REQ-015 SHALL evaluate the grant combinationally each cycle:
- if force is low and a valid WB request exists -> grant WB;
- else if the FIFO is non-empty -> grant the FIFO head;
- else -> no write.
REQ-016 SHALL drive rf_Write = 1 with the granted wr/wd; when there is no grant, rf_Write = 0, rf_WR = 0 and rf_WD = 0.
REQ-017 SHALL assert wb_stall = 1 only when a valid WB request exists and the head is granted instead.
REQ-018 SHALL pop the head on the edge ending the cycle in which it is granted.
REQ-019 SHALL give a minimum latency of 1 cycle from acceptance to write: an entry accepted at edge t can be written no earlier than the cycle following t, with no input-to-output bypass.
REQ-020 SHALL preserve FIFO order; the tail is written on push, the head advances on pop, and pointers wrap modulo 2.
REQ-021 SHALL set hz1 = (PR1 != 0) AND PR1 matches the wr of any occupied FIFO entry, or of an accepting mdu offer this cycle; hz2 likewise for PR2.
REQ-022 SHALL behave as follows on simultaneous push and pop with count == 1: count stays 1 and the new entry becomes the head after the pop.

Reset
REQ-023 SHALL, while Reset is high (asynchronous), clear count, pointers and the starvation counter to 0 and discard all FIFO contents.
REQ-024 SHALL hold these output values during and immediately after reset: rf_Write = 0, rf_WR = 0, rf_WD = 0, wb_stall = 0, mdu_ready = 1, hz1 = 0, hz2 = 0.
REQ-025 SHALL lose any entry accepted before a mid-operation Reset; it is never written.

Configuration
REQ-026 SHALL, with macro RFARB_STARVE_GUARD_EN defined, implement a 4-bit starvation counter:
- increments on each cycle the FIFO is non-empty and WB is granted;
- clears on a head grant or when the FIFO is empty;
- force = (counter >= STARVE_LIMIT).
REQ-027 SHALL, without RFARB_STARVE_GUARD_EN, tie force to 0 and remove the counter; WB then always wins and the FIFO drains only in WB-idle cycles.

Verification
REQ-028 SHALL cover: idle, then mdu offer wr=5 wd=0xA5A5A5A5 -> next cycle rf_Write=1, WR=5, WD=0xA5A5A5A5, mdu_ready stays 1.
REQ-029 SHALL cover: WB wr=3 wd=1 in the same cycle as a FIFO head wr=7 -> WB written first, head written the following idle cycle, wb_stall=0 throughout.
REQ-030 SHALL cover: three back-to-back offers while WB is busy -> mdu_ready=0 after the second acceptance; the third is held until a pop, and order is preserved.
REQ-031 SHALL cover, with RFARB_STARVE_GUARD_EN and STARVE_LIMIT=4: WB continuously busy, FIFO holding wr=9 -> on the 5th cycle the head is written and wb_stall=1 for exactly one cycle.
REQ-032 SHALL cover: FIFO holding wr=12, PR1=12, PR2=0 -> hz1=1, hz2=0; offer with wr=0 -> no write and count unchanged.
REQ-033 SHALL cover: Reset pulsed mid-cycle with 2 entries -> rf_Write=0 immediately, mdu_ready=1, and no stale write after release.
